// File: rtl/gost_round_key_sched.sv
// ---------------------------------------------------------------------------
// gost_round_key_sched
//
// Round-key scheduler for a Magma / GOST 28147-89 round core. A full key is
// captured into NUM_SUB subkeys (subkey 1 is the most-significant slice).
// A run then presents one subkey per round over a valid/ready handshake, in
// encryption or decryption order, so the round core never indexes the key.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   key_load   in   strobe capturing key_in (accepted only when idle)
//   key_in     in   raw key, KEY_W bits
//   decrypt    in   order select, sampled when a run is accepted
//   start      in   request a schedule run
//   busy       out  high while a run is in progress
//   key_valid  out  high once a key is stored
//   rk_valid   out  round key available on rk_out
//   rk_ready   in   consumer accepts the current round key
//   rk_out     out  current round key, SUBKEY_W bits (registered)
//   rk_round   out  current round index, 0..ROUNDS-1
//   done       out  one-cycle pulse after the last round key is accepted
//
// Build option:
//   GOST_KEY_ZEROIZE_EN  when defined, the key store is wiped as done pulses,
//                        so every run needs a fresh key_load. When undefined
//                        the key is kept and can be replayed by further starts.
// ---------------------------------------------------------------------------
module gost_round_key_sched #(
    parameter int KEY_W    = 256,
    parameter int SUBKEY_W = 32,
    parameter int ROUNDS   = 32,
    localparam int NUM_SUB = KEY_W / SUBKEY_W,
    localparam int PASSES  = ROUNDS / NUM_SUB,
    localparam int RW      = $clog2(ROUNDS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                decrypt,
    input  logic                start,
    output logic                busy,
    output logic                key_valid,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [SUBKEY_W-1:0] rk_out,
    output logic [RW-1:0]       rk_round,
    output logic                done
);

    localparam int IW = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [RW-1:0]       round_q, round_d;
    logic                dec_q, dec_d;
    logic                keyValid_q, keyValid_d;
    logic [SUBKEY_W-1:0] subkey_q [NUM_SUB];
    logic [SUBKEY_W-1:0] subkey_d [NUM_SUB];
    logic [SUBKEY_W-1:0] rkOut_q, rkOut_d;
    logic                rkValid_q, rkValid_d;
    logic                done_q, done_d;

    // Map a round index to a 0-based subkey slot. Each pass of NUM_SUB rounds
    // walks the subkeys either forward (1..NUM_SUB) or in reverse. Encryption
    // reverses only the final pass; decryption reverses every pass but the
    // first, which is exactly the encryption order played backwards.
    function automatic logic [IW-1:0] subIdx(input logic [RW-1:0] r, input logic dec);
        int  pass;
        int  pos;
        logic rev;
        pass = int'(r) / NUM_SUB;
        pos  = int'(r) % NUM_SUB;
        rev  = dec ? (pass != 0) : (pass == PASSES - 1);
        return rev ? IW'(NUM_SUB - 1 - pos) : IW'(pos);
    endfunction

    // Next-state logic. The round key is always computed one cycle ahead and
    // registered, so rk_out never depends combinationally on rk_ready, and a
    // handshake on one round loads the following key without a bubble.
    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        dec_d      = dec_q;
        keyValid_d = keyValid_q;
        subkey_d   = subkey_q;
        rkOut_d    = rkOut_q;
        rkValid_d  = rkValid_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_load) begin
                    for (int i = 0; i < NUM_SUB; i++) begin
                        subkey_d[i] = key_in[KEY_W-1-i*SUBKEY_W -: SUBKEY_W];
                    end
                    keyValid_d = 1'b1;
                end else if (start && keyValid_q) begin
                    state_d   = RUN;
                    dec_d     = decrypt;
                    round_d   = '0;
                    rkValid_d = 1'b1;
                    rkOut_d   = subkey_q[subIdx('0, decrypt)];
                end
            end

            RUN: begin
                if (rkValid_q && rk_ready) begin
                    if (round_q == RW'(ROUNDS - 1)) begin
                        state_d   = IDLE;
                        rkValid_d = 1'b0;
                        rkOut_d   = '0;
                        done_d    = 1'b1;
`ifdef GOST_KEY_ZEROIZE_EN
                        for (int i = 0; i < NUM_SUB; i++) begin
                            subkey_d[i] = '0;
                        end
                        keyValid_d = 1'b0;
`endif
                    end else begin
                        round_d = round_q + RW'(1);
                        rkOut_d = subkey_q[subIdx(round_q + RW'(1), dec_q)];
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers. Reset wipes the key store as well as the run state,
    // so a reset in the middle of a run abandons it without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            round_q    <= '0;
            dec_q      <= 1'b0;
            keyValid_q <= 1'b0;
            subkey_q   <= '{default: '0};
            rkOut_q    <= '0;
            rkValid_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            dec_q      <= dec_d;
            keyValid_q <= keyValid_d;
            subkey_q   <= subkey_d;
            rkOut_q    <= rkOut_d;
            rkValid_q  <= rkValid_d;
            done_q     <= done_d;
        end
    end

    assign busy      = (state_q == RUN);
    assign key_valid = keyValid_q;
    assign rk_valid  = rkValid_q;
    assign rk_out    = rkOut_q;
    assign rk_round  = round_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gost_round_key_sched.sv
// ---------------------------------------------------------------------------
// tb_gost_round_key_sched
//
// Directed bench for gost_round_key_sched with the default 256/32/32 sizing.
// A transaction-level model tracks the stored key, the run mode and the
// round being offered; the expected round key is derived straight from the
// pass/position ordering rules. A compare process checks the DUT against the
// model every cycle, and the directed sequence pins the model with literal
// round keys taken from the reference key.
// ---------------------------------------------------------------------------
module tb_gost_round_key_sched;

    localparam int KEY_W    = 256;
    localparam int SUBKEY_W = 32;
    localparam int ROUNDS   = 32;
    localparam int NUM_SUB  = KEY_W / SUBKEY_W;
    localparam int PASSES   = ROUNDS / NUM_SUB;
    localparam int RW       = $clog2(ROUNDS);

    localparam logic [KEY_W-1:0] REF_KEY =
        256'hffeeddcc_bbaa9988_77665544_33221100_f0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff;

    logic                clk = 1'b0;
    logic                rst;
    logic                key_load;
    logic [KEY_W-1:0]    key_in;
    logic                decrypt;
    logic                start;
    logic                busy;
    logic                key_valid;
    logic                rk_valid;
    logic                rk_ready;
    logic [SUBKEY_W-1:0] rk_out;
    logic [RW-1:0]       rk_round;
    logic                done;

    int vectorCount = 0;
    int missCount   = 0;

    // Model state
    logic [KEY_W-1:0] mKey      = '0;
    logic             mKeyValid = 1'b0;
    logic             mBusy     = 1'b0;
    logic             mDec      = 1'b0;
    logic             mDone     = 1'b0;
    int               mRound    = 0;
    logic             checkEn   = 1'b0;

    // Observations collected by the compare process
    logic [SUBKEY_W-1:0] obs [ROUNDS];
    int validCycles = 0;
    int doneCount   = 0;
    int edges;

    gost_round_key_sched #(
        .KEY_W    (KEY_W),
        .SUBKEY_W (SUBKEY_W),
        .ROUNDS   (ROUNDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .start     (start),
        .busy      (busy),
        .key_valid (key_valid),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_round  (rk_round),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Expected round key from the ordering rules: slot 1 is the top slice.
    function automatic logic [SUBKEY_W-1:0] expKey(input logic [KEY_W-1:0] k,
                                                    input logic dec, input int r);
        int pass;
        int pos;
        int sub;
        logic rev;
        pass = r / NUM_SUB;
        pos  = r % NUM_SUB;
        rev  = dec ? (pass > 0) : (pass == PASSES - 1);
        sub  = rev ? (NUM_SUB - pos) : (pos + 1);
        return k[KEY_W - sub*SUBKEY_W +: SUBKEY_W];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        vectorCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: one transaction step per rising edge from the inputs.
    always @(posedge clk) begin
        checkEn = 1'b1;
        if (rst) begin
            mKey = '0; mKeyValid = 1'b0; mBusy = 1'b0;
            mDec = 1'b0; mDone = 1'b0; mRound = 0;
        end else begin
            mDone = 1'b0;
            if (!mBusy) begin
                if (key_load) begin
                    mKey = key_in;
                    mKeyValid = 1'b1;
                end else if (start && mKeyValid) begin
                    mBusy = 1'b1;
                    mDec = decrypt;
                    mRound = 0;
                end
            end else if (rk_ready) begin
                if (mRound == ROUNDS - 1) begin
                    mBusy = 1'b0;
                    mDone = 1'b1;
`ifdef GOST_KEY_ZEROIZE_EN
                    mKey = '0;
                    mKeyValid = 1'b0;
`endif
                end else begin
                    mRound++;
                end
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("busy", 64'(busy), 64'(mBusy));
            checkOutput("rk_valid", 64'(rk_valid), 64'(mBusy));
            checkOutput("key_valid", 64'(key_valid), 64'(mKeyValid));
            checkOutput("done", 64'(done), 64'(mDone));
            if (mBusy) begin
                checkOutput("rk_round", 64'(rk_round), 64'(mRound));
                checkOutput("rk_out", 64'(rk_out), 64'(expKey(mKey, mDec, mRound)));
            end
            if (rk_valid && rk_ready) begin
                obs[rk_round] = rk_out;
                validCycles++;
            end
            if (done) doneCount++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearObs();
        for (int i = 0; i < ROUNDS; i++) obs[i] = '0;
        validCycles = 0;
        doneCount = 0;
    endtask

    task automatic loadKey(input logic [KEY_W-1:0] k);
        key_in = k;
        key_load = 1'b1;
        tick(1);
        key_load = 1'b0;
    endtask

    // Run one schedule, optionally stalling rk_ready for stallLen cycles when
    // round stallRound is offered; returns edges from start to visible done.
    task automatic applyStimulus(input logic dec, input int stallRound,
                                 input int stallLen, input logic [SUBKEY_W-1:0] holdKey,
                                 output int nEdges);
        logic stalled;
        stalled = 1'b0;
        decrypt = dec;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        decrypt = ~dec;
        nEdges = 1;
        while (!done && nEdges < 200) begin
            if (stallLen > 0 && !stalled && rk_valid && int'(rk_round) == stallRound) begin
                rk_ready = 1'b0;
                repeat (stallLen) begin
                    tick(1);
                    nEdges++;
                    checkOutput("holdKey", 64'(rk_out), 64'(holdKey));
                    checkOutput("holdRound", 64'(rk_round), 64'(stallRound));
                end
                rk_ready = 1'b1;
                stalled = 1'b1;
            end
            tick(1);
            nEdges++;
        end
        checkOutput("runTimeout", 64'(done), 64'(1));
        tick(2);
    endtask

    initial begin
        rst = 1'b1; key_load = 1'b0; key_in = '0; decrypt = 1'b0;
        start = 1'b0; rk_ready = 1'b1;
        tick(3);
        checkOutput("rstBusy", 64'(busy), 64'(0));
        checkOutput("rstKeyValid", 64'(key_valid), 64'(0));
        checkOutput("rstRkValid", 64'(rk_valid), 64'(0));
        checkOutput("rstRkOut", 64'(rk_out), 64'(0));
        checkOutput("rstRkRound", 64'(rk_round), 64'(0));
        checkOutput("rstDone", 64'(done), 64'(0));
        rst = 1'b0;
        tick(1);

        // start without a stored key is ignored
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        checkOutput("noKeyBusy", 64'(busy), 64'(0));
        checkOutput("noKeyRkValid", 64'(rk_valid), 64'(0));

        // key_load wins over start in the same cycle
        key_in = REF_KEY; key_load = 1'b1; start = 1'b1;
        tick(1);
        key_load = 1'b0; start = 1'b0;
        tick(2);
        checkOutput("loadStartKeyValid", 64'(key_valid), 64'(1));
        checkOutput("loadStartBusy", 64'(busy), 64'(0));

        // encryption order
        clearObs();
        applyStimulus(1'b0, -1, 0, '0, edges);
        checkOutput("encEdges", 64'(edges), 64'(33));
        checkOutput("encValidCycles", 64'(validCycles), 64'(32));
        checkOutput("encDoneCount", 64'(doneCount), 64'(1));
        checkOutput("encR0", 64'(obs[0]), 64'(32'hffeeddcc));
        checkOutput("encR1", 64'(obs[1]), 64'(32'hbbaa9988));
        checkOutput("encR7", 64'(obs[7]), 64'(32'hfcfdfeff));
        checkOutput("encR24", 64'(obs[24]), 64'(32'hfcfdfeff));
        checkOutput("encR31", 64'(obs[31]), 64'(32'hffeeddcc));

`ifdef GOST_KEY_ZEROIZE_EN
        // key wiped at done: a second start must not run
        checkOutput("zeroKeyValid", 64'(key_valid), 64'(0));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        checkOutput("zeroRestartBusy", 64'(busy), 64'(0));
        loadKey(REF_KEY);
`else
        // key retained: a second start replays the same sequence
        checkOutput("keepKeyValid", 64'(key_valid), 64'(1));
        clearObs();
        applyStimulus(1'b0, -1, 0, '0, edges);
        checkOutput("replayEdges", 64'(edges), 64'(33));
        checkOutput("replayDoneCount", 64'(doneCount), 64'(1));
        checkOutput("replayR0", 64'(obs[0]), 64'(32'hffeeddcc));
        checkOutput("replayR31", 64'(obs[31]), 64'(32'hffeeddcc));
`endif

        // decryption order
        clearObs();
        applyStimulus(1'b1, -1, 0, '0, edges);
        checkOutput("decEdges", 64'(edges), 64'(33));
        checkOutput("decR0", 64'(obs[0]), 64'(32'hffeeddcc));
        checkOutput("decR7", 64'(obs[7]), 64'(32'hfcfdfeff));
        checkOutput("decR8", 64'(obs[8]), 64'(32'hfcfdfeff));
        checkOutput("decR15", 64'(obs[15]), 64'(32'hffeeddcc));
        checkOutput("decR31", 64'(obs[31]), 64'(32'hffeeddcc));
`ifdef GOST_KEY_ZEROIZE_EN
        loadKey(REF_KEY);
`endif

        // backpressure at round 3 (subkey 4) for 5 cycles
        clearObs();
        applyStimulus(1'b0, 3, 5, 32'h33221100, edges);
        checkOutput("stallEdges", 64'(edges), 64'(38));
        checkOutput("stallValidCycles", 64'(validCycles), 64'(32));
        checkOutput("stallR4", 64'(obs[4]), 64'(32'hf0f1f2f3));
`ifdef GOST_KEY_ZEROIZE_EN
        loadKey(REF_KEY);
`endif

        // reset in the middle of a run
        clearObs();
        decrypt = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        edges = 0;
        while (!(rk_valid && int'(rk_round) == 10) && edges < 50) begin
            tick(1);
            edges++;
        end
        checkOutput("reachRound10", 64'(rk_round), 64'(10));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("abortBusy", 64'(busy), 64'(0));
        checkOutput("abortRkValid", 64'(rk_valid), 64'(0));
        checkOutput("abortKeyValid", 64'(key_valid), 64'(0));
        checkOutput("abortDone", 64'(done), 64'(0));
        tick(3);
        checkOutput("abortDoneCount", 64'(doneCount), 64'(0));
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        checkOutput("abortRestartBusy", 64'(busy), 64'(0));

        // reload and run once more after the abort
        loadKey(REF_KEY);
        clearObs();
        applyStimulus(1'b1, -1, 0, '0, edges);
        checkOutput("reloadEdges", 64'(edges), 64'(33));
        checkOutput("reloadDoneCount", 64'(doneCount), 64'(1));

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
